// File: rtl/cordic_pkg.sv
// Shared definitions for the iterative CORDIC engine: FSM encoding,
// mode constants and the Q30 arctangent seed table.
package cordic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic MODE_ROT = 1'b0;
    localparam logic MODE_VEC = 1'b1;

    // floor(atan(2^-i) * 2^30), i = 0..31
    localparam logic [31:0] ATAN_Q30 [0:31] = '{
        32'd843314856, 32'd497837829, 32'd263043836, 32'd133525158,
        32'd67021686,  32'd33543515,  32'd16775850,  32'd8388437,
        32'd4194282,   32'd2097149,   32'd1048575,   32'd524287,
        32'd262143,    32'd131071,    32'd65535,     32'd32767,
        32'd16383,     32'd8191,      32'd4095,      32'd2047,
        32'd1023,      32'd511,       32'd255,       32'd127,
        32'd63,        32'd31,        32'd15,        32'd7,
        32'd3,         32'd1,         32'd0,         32'd0
    };

endpackage

// File: rtl/cordic_atan_rom.sv
// Combinational arctangent lookup: rescales the Q30 seed table to FRAC
// fractional bits and fits it to the datapath width.
module cordic_atan_rom
    import cordic_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int FRAC   = 16
) (
    input  logic [4:0]        index,
    output logic [DATA_W-1:0] angle
);

    logic [31:0] scaled;

    // Table entries are non-negative, so a logical shift equals the arithmetic one
    always_comb begin
        scaled = ATAN_Q30[index] >> (30 - FRAC);
    end

    assign angle = DATA_W'(scaled);

endmodule

// File: rtl/cordic_iter_engine.sv
// Iterative CORDIC engine: one micro-rotation per clock in rotation
// (sin/cos) or vectoring (magnitude/atan) mode, start/busy/done handshake.
module cordic_iter_engine
    import cordic_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int FRAC   = 16,
    parameter int ITER   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              mode,
    input  logic [DATA_W-1:0] x_in,
    input  logic [DATA_W-1:0] y_in,
    input  logic [DATA_W-1:0] z_in,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] x_out,
    output logic [DATA_W-1:0] y_out,
    output logic [DATA_W-1:0] z_out
);

    localparam int            CW   = $clog2(ITER + 1);
    localparam logic [CW-1:0] LAST = CW'(ITER - 1);

    state_t                    state;
    logic [CW-1:0]             iter_cnt;
    logic                      mode_reg;
    logic                      busy_reg;
    logic                      done_reg;
    logic signed [DATA_W-1:0]  x_reg, y_reg, z_reg;

    logic [4:0]                rom_index;
    logic [DATA_W-1:0]         atan_raw;
    logic signed [DATA_W-1:0]  atan_val;
    logic signed [DATA_W-1:0]  x_shift, y_shift;
    logic signed [DATA_W-1:0]  x_next, y_next, z_next;
    logic                      dir_pos;

    assign rom_index = 5'(iter_cnt);

    cordic_atan_rom #(
        .DATA_W (DATA_W),
        .FRAC   (FRAC)
    ) u_atan_rom (
        .index (rom_index),
        .angle (atan_raw)
    );

    assign atan_val = $signed(atan_raw);

    // One micro-rotation: barrel shifts, direction decision and add/sub
    always_comb begin
        x_shift = x_reg >>> iter_cnt;
        y_shift = y_reg >>> iter_cnt;
        // Rotation drives z toward zero; vectoring drives y toward zero
        dir_pos = (mode_reg == MODE_ROT) ? ~z_reg[DATA_W-1] : y_reg[DATA_W-1];
        if (dir_pos) begin
            x_next = x_reg - y_shift;
            y_next = y_reg + x_shift;
            z_next = z_reg - atan_val;
        end else begin
            x_next = x_reg + y_shift;
            y_next = y_reg - x_shift;
            z_next = z_reg + atan_val;
        end
    end

    // FSM, iteration counter, working registers and registered handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            iter_cnt <= '0;
            mode_reg <= MODE_ROT;
            busy_reg <= 1'b0;
            done_reg <= 1'b0;
            x_reg    <= '0;
            y_reg    <= '0;
            z_reg    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done_reg <= 1'b0;
                    if (start) begin
                        x_reg    <= $signed(x_in);
                        y_reg    <= $signed(y_in);
                        z_reg    <= $signed(z_in);
                        mode_reg <= mode;
                        iter_cnt <= '0;
                        busy_reg <= 1'b1;
                        state    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    x_reg    <= x_next;
                    y_reg    <= y_next;
                    z_reg    <= z_next;
                    iter_cnt <= iter_cnt + CW'(1);
                    if (iter_cnt == LAST) begin
                        done_reg <= 1'b1;
                        state    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // busy and done drop on the same edge
                    done_reg <= 1'b0;
                    busy_reg <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: begin
                    done_reg <= 1'b0;
                    busy_reg <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy  = busy_reg;
    assign done  = done_reg;
    assign x_out = x_reg;
    assign y_out = y_reg;
    assign z_out = z_reg;

endmodule

// File: tb/tb_cordic_iter_engine.sv
// Self-checking bench for cordic_iter_engine: directed and random
// operations compared against an arithmetic CORDIC reference model.
module tb_cordic_iter_engine;

    localparam int ITER   = 16;
    localparam int P      = ITER + 2;
    localparam int BUDGET = 100;

    // atan(2^-i) in Q16, as listed for the angle table
    localparam int ATAN16 [16] = '{51471, 30385, 16054, 8149, 4090, 2047, 1023, 511,
                                   255, 127, 63, 31, 15, 7, 3, 1};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        start1 = 1'b0;
    logic        mode = 1'b0;
    logic [31:0] x_in = '0, y_in = '0, z_in = '0;
    logic        busy, done, busy1, done1;
    logic [31:0] x_out, y_out, z_out, x_out1, y_out1, z_out1;
    logic [4:0]  rom_idx = '0;
    logic [31:0] rom16_angle, rom30_angle;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cordic_iter_engine #(.DATA_W(32), .FRAC(16), .ITER(ITER)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
        .x_in(x_in), .y_in(y_in), .z_in(z_in),
        .busy(busy), .done(done),
        .x_out(x_out), .y_out(y_out), .z_out(z_out)
    );

    cordic_iter_engine #(.DATA_W(32), .FRAC(16), .ITER(1)) u_one (
        .clk(clk), .rst_n(rst_n), .start(start1), .mode(mode),
        .x_in(x_in), .y_in(y_in), .z_in(z_in),
        .busy(busy1), .done(done1),
        .x_out(x_out1), .y_out(y_out1), .z_out(z_out1)
    );

    cordic_atan_rom #(.DATA_W(32), .FRAC(16)) u_rom16 (.index(rom_idx), .angle(rom16_angle));
    cordic_atan_rom #(.DATA_W(32), .FRAC(30)) u_rom30 (.index(rom_idx), .angle(rom30_angle));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // CORDIC as textbook arithmetic on 32-bit wrapping integers
    function automatic void model(input bit vec, input int xi, input int yi, input int zi,
                                  input int iters, output int xo, output int yo, output int zo);
        int x = xi, y = yi, z = zi;
        for (int i = 0; i < iters; i++) begin
            int d  = vec ? ((y < 0) ? 1 : -1) : ((z >= 0) ? 1 : -1);
            int xs = x >>> i;
            int ys = y >>> i;
            int xn = x - d * ys;
            int yn = y + d * xs;
            z = z - d * ATAN16[i];
            x = xn;
            y = yn;
        end
        xo = x; yo = y; zo = z;
    endfunction

    // One full operation on the ITER engine (which=0) or the ITER=1 engine (which=1)
    task automatic do_op(input bit which, input bit vec, input int xi, input int yi,
                         input int zi, input string tag);
        int n, ex, ey, ez;
        int iters = which ? 1 : ITER;
        model(vec, xi, yi, zi, iters, ex, ey, ez);
        @(negedge clk);
        mode = vec; x_in = xi; y_in = yi; z_in = zi;
        if (which) start1 = 1'b1; else start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; start1 = 1'b0;
        check({tag, "_busy_rise"}, {31'd0, which ? busy1 : busy}, 32'd1);
        n = 0;
        while (((which ? done1 : done) !== 1'b1) && n < BUDGET) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_latency"}, n, iters);
        check({tag, "_x"}, which ? x_out1 : x_out, ex);
        check({tag, "_y"}, which ? y_out1 : y_out, ey);
        check({tag, "_z"}, which ? z_out1 : z_out, ez);
        $display("op %s mode=%0d in=(%0d,%0d,%0d) out=(%0d,%0d,%0d) edges=%0d", tag, vec, xi, yi, zi,
                 $signed(which ? x_out1 : x_out), $signed(which ? y_out1 : y_out),
                 $signed(which ? z_out1 : z_out), n);
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, {31'd0, which ? done1 : done}, 32'd0);
        check({tag, "_busy_fall"}, {31'd0, which ? busy1 : busy}, 32'd0);
        check({tag, "_x_held"}, which ? x_out1 : x_out, ex);
    endtask

    initial begin
        int ex, ey, ez, xi, yi, zi;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_x", x_out, 32'd0);
        check("rst_y", y_out, 32'd0);
        check("rst_z", z_out, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Angle table probes
        for (int i = 0; i < 16; i++) begin
            rom_idx = 5'(i);
            #1;
            check($sformatf("rom16_%0d", i), rom16_angle, ATAN16[i]);
        end
        rom_idx = 5'd16;
        #1;
        check("rom16_16", rom16_angle, 32'd0);
        rom_idx = 5'd0;
        #1;
        check("rom30_0", rom30_angle, 32'd843314856);

        // Directed rotation / vectoring with the quoted tolerances
        do_op(0, 0, 39797, 0, 51471, "rot_pi4");
        check("rot_pi4_x_tol", {31'd0, iabs($signed(x_out) - 46341) <= 16}, 32'd1);
        check("rot_pi4_y_tol", {31'd0, iabs($signed(y_out) - 46341) <= 16}, 32'd1);
        check("rot_pi4_z_tol", {31'd0, iabs($signed(z_out)) <= 2}, 32'd1);
        do_op(0, 1, 65536, 65536, 0, "vec_45");
        check("vec_45_z_tol", {31'd0, iabs($signed(z_out) - 51471) <= 2}, 32'd1);
        check("vec_45_x_tol", {31'd0, iabs($signed(x_out) - 152627) <= 16}, 32'd1);
        check("vec_45_y_tol", {31'd0, iabs($signed(y_out)) <= 16}, 32'd1);
        do_op(0, 0, 39797, 0, -51471, "rot_neg");
        check("rot_neg_y_tol", {31'd0, iabs($signed(y_out) + 46341) <= 16}, 32'd1);
        do_op(0, 1, 32'h7fffffff, 32'h7fffffff, 0, "vec_wrap");

        // Randomised operations
        for (int k = 0; k < 6; k++) begin
            xi = int'($urandom_range(60000, 1000));
            yi = int'($urandom_range(20000, 0)) - 10000;
            zi = int'($urandom_range(204000, 0)) - 102000;
            do_op(0, 0, xi, yi, zi, $sformatf("rnd_rot%0d", k));
        end
        for (int k = 0; k < 6; k++) begin
            xi = int'($urandom_range(200000, 1));
            yi = int'($urandom_range(400000, 0)) - 200000;
            zi = int'($urandom_range(1000, 0));
            do_op(0, 1, xi, yi, zi, $sformatf("rnd_vec%0d", k));
        end
        for (int k = 0; k < 2; k++) begin
            do_op(0, k[0], int'($urandom), int'($urandom), int'($urandom), $sformatf("rnd_any%0d", k));
        end

        // ITER = 1 engine: a single micro-rotation
        do_op(1, 0, 39797, 0, 51471, "one_rot");
        do_op(1, 1, 65536, -20000, 7, "one_vec");

        // start held high: accepted only in IDLE, done every ITER+2 cycles
        model(0, 30000, 1000, 20000, ITER, ex, ey, ez);
        @(negedge clk);
        mode = 0; x_in = 30000; y_in = 1000; z_in = 20000;
        start = 1'b1;
        for (int c = 0; c < 3 * P; c++) begin
            @(posedge clk); #1;
            check($sformatf("hold_busy_c%0d", c), {31'd0, busy}, {31'd0, (c % P) != ITER + 1});
            check($sformatf("hold_done_c%0d", c), {31'd0, done}, {31'd0, (c % P) == ITER});
            if ((c % P) == ITER) check($sformatf("hold_x_c%0d", c), x_out, ex);
        end
        start = 1'b0;
        $display("op hold_start pulses=3 period=%0d", P);

        // Reset in the middle of a run
        @(negedge clk);
        mode = 0; x_in = 39797; y_in = 0; z_in = 51471;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        check("midrst_x", x_out, 32'd0);
        check("midrst_y", y_out, 32'd0);
        check("midrst_z", z_out, 32'd0);
        $display("op mid_run_reset applied");
        @(negedge clk);
        rst_n = 1'b1;
        do_op(0, 0, 39797, 0, 51471, "post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cordic_iter_engine.md
# cordic_iter_engine

Iterative, parametrised CORDIC engine that runs one micro-rotation per clock, in either rotation mode (sin/cos) or vectoring mode (magnitude/atan). It is the sequential successor to our fixed 16-entry Q16 arctangent table. Iteration count, data width and angle fraction bits are parameters. The engine sits between the angle/vector request source and the downstream scaling logic, and uses a start/busy/done handshake.

## Interface
- `DATA_W`, default 32: width of x, y and z. Signed two's complement.
- `FRAC`, default 16: fractional bits of the z angle, in radians. Range 1..30.
- `ITER`, default 16: number of micro-rotations. Range 1..32, and ITER ≤ DATA_W.
- `clk`: input, 1 bit. Single clock; all state changes on the rising edge.
- `rst_n`: input, 1 bit. Asynchronous, active-low reset.
- `start`: input, 1 bit. Request pulse. Sampled only in IDLE.
- `mode`: input, 1 bit. 0 = rotation, 1 = vectoring. Latched when start is accepted.
- `x_in`, `y_in`, `z_in`: input, DATA_W each. Operands, latched when start is accepted.
- `busy`: output, 1 bit. High whenever state ≠ IDLE.
- `done`: output, 1 bit. One-cycle pulse; results are valid while it is high.
- `x_out`, `y_out`, `z_out`: output, DATA_W each. Working registers. Valid at done and held until the next accepted start.

## Operation
- FSM states: IDLE → RUN → DONE → IDLE.
- **IDLE, start = 1:** load x, y, z and mode; clear iteration counter i; go to RUN. With start = 0, stay in IDLE and hold all registers.
- **RUN:** perform one micro-rotation per cycle for i = 0..ITER-1.
  - Direction d = +1 or -1:
    - Rotation mode: d = +1 if z ≥ 0, else -1.
    - Vectoring mode: d = +1 if y < 0, else -1.
  - Updates, computed from the pre-edge values:
    - x' = x − d·(y >>> i)
    - y' = y + d·(x >>> i)
    - z' = z − d·atan[i]
  - Shifts are arithmetic. Add/subtract wraps modulo 2^DATA_W; there is no saturation.
  - After iteration ITER-1, go to DONE.
- **DONE:** done = 1 for exactly one cycle, then go to IDLE.
- **start while busy** (RUN or DONE): ignored and not queued.
- **Gain:** no CORDIC gain compensation (K ≈ 1.64676). The caller pre-scales x_in by 1/K when unit-gain output is needed.
- **Angle table:** atan[i] = floor(atan(2^-i)·2^FRAC).
  - Generated as ATAN_Q30[i] >>> (30 − FRAC), where ATAN_Q30[i] = floor(atan(2^-i)·2^30).
  - For FRAC = 16 the first 16 entries are exactly: 51471, 30385, 16054, 8149, 4090, 2047, 1023, 511, 255, 127, 63, 31, 15, 7, 3, 1.
- **Convergence:** valid only for |z_in| ≤ ~1.7433 rad (rotation) or x_in > 0 (vectoring). Outside that range the results are undefined but deterministic.

## Timing
- **Reset:** rst_n low forces, asynchronously:
  - state = IDLE, i = 0, mode register = 0;
  - busy = 0, done = 0;
  - x_out = y_out = z_out = 0.
  - Reset mid-RUN abandons the operation; no done is produced.
- **Latency:** start sampled at edge k.
  - RUN covers edges k+1 … k+ITER.
  - DONE (done = 1) is visible in the cycle after edge k+ITER.
  - IDLE after edge k+ITER+1.
  - Total from start edge to done visible: ITER+1 clocks. Throughput: one operation per ITER+2 cycles.
- **busy:** rises in the cycle after the start edge and falls together with done.
- **Outputs:** x/y/z_out change every RUN cycle. They are stable from DONE until the next accepted start.
- **Back-to-back:** start asserted during DONE is ignored. The earliest re-start is the first IDLE cycle.

## Structure
- Package `cordic_pkg` holds:
  - ATAN_Q30[0:31] constant array;
  - FSM state encoding (IDLE, RUN, DONE);
  - MODE_ROT / MODE_VEC constants.
- Sub-module `cordic_atan_rom` (parameter FRAC; input index[4:0]; output DATA_W angle). Purely combinational; returns ATAN_Q30[index] >>> (30−FRAC), sign-extended or truncated to DATA_W.
- The engine holds the FSM, iteration counter ($clog2(ITER+1) bits), datapath registers and barrel shifters.

## Test plan
- **Rotation:** defaults, mode = 0, x_in = 39797, y_in = 0, z_in = 51471 (π/4) → done at start+17 cycles; x_out ≈ y_out ≈ 46341 (±16 LSB), z_out ≈ 0 (±2). Results bit-exact to the reference model.
- **Vectoring:** mode = 1, x_in = 65536, y_in = 65536, z_in = 0 → z_out ≈ 51471 (±2), x_out ≈ 152627 (±16), y_out ≈ 0 (±16).
- **Table check:** FRAC = 16, probe cordic_atan_rom indices 0..15 → exactly 51471 … 1 as listed. FRAC = 30, index 0 → 843314856.
- **Handshake:** start held high continuously → accepted only in IDLE. done is a single-cycle pulse every ITER+2 cycles; busy never glitches.
- **Reset mid-run:** rst_n pulled low at RUN iteration 5 → busy, done and all outputs are 0 immediately. Next start runs normally with correct results.
- **Boundaries:** ITER = 1 → done at start+2, one micro-rotation only. Negative z_in = −51471 in rotation mode → y_out ≈ −46341. Wrap case x_in = y_in = 2^31−1 in vectoring mode → matches the modulo model, no X.
